tcdm_bank_rr_arbiter: RTL and testbench
=======================================

Name: tcdm_bank_rr_arbiter

Overview:
Per-bank request arbiter placed directly upstream of one TCDM SRAM bank. Merges NbInit initiator ports (cores, DMA, HWPE) onto the single bank port using round-robin arbitration. Tracks which initiator won each accepted request and routes the bank's 1-cycle-latency read data and response id back to that initiator with a valid strobe. One instance per bank; a bank sees at most one request per cycle.

Parameters:
NbInit, 4, number of initiator ports (>=1)
AddrWidth, 32, request address width
DataWidth, 32, data width
BeWidth, DataWidth/8, byte-enable width
IdWidth, 1, transaction id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
init_req_i  in  NbInit  request per initiator
init_add_i  in  NbInit x AddrWidth  address
init_wen_i  in  NbInit  1=read, 0=write
init_data_i  in  NbInit x DataWidth  write data
init_be_i  in  NbInit x BeWidth  byte enables
init_id_i  in  NbInit x IdWidth  request id
init_gnt_o  out  NbInit  grant, one-hot or zero
init_r_valid_o  out  NbInit  response valid, one-hot or zero
init_r_data_o  out  DataWidth  read data, broadcast to all initiators
init_r_id_o  out  IdWidth  response id, broadcast
bank_req_o  out  1  bank request
bank_add_o  out  AddrWidth  bank address
bank_wen_o  out  1  bank write-enable (1=read)
bank_data_o  out  DataWidth  bank write data
bank_be_o  out  BeWidth  bank byte enables
bank_id_o  out  IdWidth  bank request id
bank_gnt_i  in  1  bank grant
bank_r_data_i  in  DataWidth  bank read data, valid 1 cycle after handshake
bank_r_id_i  in  IdWidth  bank response id, valid 1 cycle after handshake

Behaviour:
- Clock clk_i, single domain. Reset rst_ni asynchronous, active-low.
- State: rr_ptr_q (clog2(NbInit) bits, width 1 when NbInit=1), resp_valid_q (1), resp_idx_q (clog2(NbInit)).
- Reset values: rr_ptr_q=0, resp_valid_q=0, resp_idx_q=0. Consequently init_r_valid_o=0. Combinational outputs follow inputs during reset: bank_req_o=|init_req_i, init_gnt_o=0 unless bank_gnt_i.
- Pick (combinational): winner = first index i with init_req_i[i]=1, scanning rr_ptr_q, rr_ptr_q+1, ..., wrapping modulo NbInit.
- bank_req_o = OR of init_req_i. bank_add/wen/data/be/id_o = winner's fields. When no request, mux select is rr_ptr_q and values are don't-care.
- init_gnt_o[winner] = bank_gnt_i & bank_req_o. All other bits are 0.
- Handshake hs = bank_req_o & bank_gnt_i. On hs: rr_ptr_q <= (winner+1) mod NbInit; resp_valid_q <= 1; resp_idx_q <= winner. With no hs: rr_ptr_q holds and resp_valid_q <= 0.
- Response: init_r_valid_o[resp_idx_q] = resp_valid_q, exactly 1 cycle after hs. This applies to reads and writes (write gets a valid with don't-care data). init_r_data_o = bank_r_data_i; init_r_id_o = bank_r_id_i, passed through unregistered.
- Throughput: one handshake per cycle. Back-to-back handshakes give back-to-back r_valid pulses, each to its own winner.
- bank_gnt_i=0: no grant, pointer frozen, no response next cycle.
- Initiators must hold req and fields stable until granted (OBI). Withdrawing req before grant is illegal; behaviour is simply re-arbitration with no corruption.
- Wrap-around: pointer at NbInit-1 advances to 0. NbInit=1: pointer constant 0, block reduces to a pass-through plus a valid register.
- Reset asserted mid-operation: pending response is dropped (resp_valid_q=0) and pointer returns to 0.

Decomposition:
- Package tcdm_arb_pkg: function rr_pick(req vector, ptr) returning the index, and the index-width localparam helper (IdxWidth = NbInit>1 ? clog2(NbInit) : 1).
- One natural combinational sub-module: tcdm_rr_pick (req vector + pointer in, winner index + any-valid out). It can be reused by other per-bank arbiters.

Test Plan:
- Reset, then a single read: init 2 reads address 0x100 with id=1. Required: gnt_o=4'b0100 same cycle, bank_add_o=0x100; next cycle r_valid_o=4'b0100, r_data_o equals bank data, r_id_o=1; rr_ptr=3.
- All 4 requesting continuously, bank_gnt_i=1: grants go 0,1,2,3,0 in consecutive cycles; r_valid_o follows 1 cycle later with the same sequence.
- Pointer wrap with sparse requests: ptr=3 and req=4'b0011. Required: winner 0, then next cycle winner 1, then ptr=2.
- Bank stall: req=4'b1010, bank_gnt_i=0 for 3 cycles. Required: gnt_o=0, pointer unchanged, r_valid_o=0; on gnt_i=1, initiator 1 is granted first (ptr=0).
- Write: init 3 writes data 0xDEADBEEF with be=4'b0011. Required: bank_wen_o=0, bank_be_o=4'b0011; r_valid_o[3] pulses once the next cycle.
- Reset mid-flight: assert rst_ni=0 in the cycle after a handshake. Required: r_valid_o=0 immediately, pointer 0 after release.

Source files
------------

// File: rtl/tcdm_arb_pkg.sv
// rtl/tcdm_arb_pkg.sv - shared helpers for per-bank TCDM round-robin arbiters
package tcdm_arb_pkg;

  localparam int unsigned MaxInit     = 64;
  localparam int unsigned MaxIdxWidth = 6;

  function automatic int unsigned idx_width(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  // First requesting index at or after ptr, wrapping modulo nb; ptr when nobody requests.
  function automatic logic [MaxIdxWidth-1:0] rr_pick(
    input logic [MaxInit-1:0]     req,
    input logic [MaxIdxWidth-1:0] ptr,
    input logic [MaxIdxWidth:0]   nb
  );
    logic [MaxIdxWidth:0]   idx;
    logic [MaxIdxWidth-1:0] pick;
    logic                   found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MaxInit; k++) begin
      idx = {1'b0, ptr} + (MaxIdxWidth + 1)'(k);
      if (idx >= nb) idx = idx - nb;
      if (((MaxIdxWidth + 1)'(k) < nb) && !found && req[idx[MaxIdxWidth-1:0]]) begin
        pick  = idx[MaxIdxWidth-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tcdm_rr_pick.sv
// rtl/tcdm_rr_pick.sv - combinational round-robin winner selection
module tcdm_rr_pick
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NbInit   = 4,
  parameter int unsigned IdxWidth = idx_width(NbInit)
) (
  input  logic [NbInit-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  assign idx_o   = IdxWidth'(rr_pick(MaxInit'(req_i), MaxIdxWidth'(ptr_i),
                                     (MaxIdxWidth + 1)'(NbInit)));
  assign valid_o = |req_i;

endmodule

// File: rtl/tcdm_bank_rr_arbiter.sv
// rtl/tcdm_bank_rr_arbiter.sv - round-robin merge of initiators onto one TCDM bank
module tcdm_bank_rr_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NbInit    = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NbInit-1:0]                 init_req_i,
  input  logic [NbInit-1:0][AddrWidth-1:0]  init_add_i,
  input  logic [NbInit-1:0]                 init_wen_i,
  input  logic [NbInit-1:0][DataWidth-1:0]  init_data_i,
  input  logic [NbInit-1:0][BeWidth-1:0]    init_be_i,
  input  logic [NbInit-1:0][IdWidth-1:0]    init_id_i,
  output logic [NbInit-1:0]                 init_gnt_o,
  output logic [NbInit-1:0]                 init_r_valid_o,
  output logic [DataWidth-1:0]              init_r_data_o,
  output logic [IdWidth-1:0]                init_r_id_o,
  output logic                              bank_req_o,
  output logic [AddrWidth-1:0]              bank_add_o,
  output logic                              bank_wen_o,
  output logic [DataWidth-1:0]              bank_data_o,
  output logic [BeWidth-1:0]                bank_be_o,
  output logic [IdWidth-1:0]                bank_id_o,
  input  logic                              bank_gnt_i,
  input  logic [DataWidth-1:0]              bank_r_data_i,
  input  logic [IdWidth-1:0]                bank_r_id_i
);

  localparam int unsigned IdxWidth = idx_width(NbInit);

  logic [IdxWidth-1:0] rr_ptr_q;
  logic [IdxWidth-1:0] resp_idx_q;
  logic                resp_valid_q;
  logic [IdxWidth-1:0] winner;
  logic [IdxWidth-1:0] ptr_next;
  logic                any_req;
  logic                hs;

  tcdm_rr_pick #(
    .NbInit  (NbInit),
    .IdxWidth(IdxWidth)
  ) i_pick (
    .req_i  (init_req_i),
    .ptr_i  (rr_ptr_q),
    .idx_o  (winner),
    .valid_o(any_req)
  );

  assign bank_req_o  = any_req;
  assign bank_add_o  = init_add_i[winner];
  assign bank_wen_o  = init_wen_i[winner];
  assign bank_data_o = init_data_i[winner];
  assign bank_be_o   = init_be_i[winner];
  assign bank_id_o   = init_id_i[winner];
  assign hs          = bank_req_o & bank_gnt_i;

  assign ptr_next = (winner == IdxWidth'(NbInit - 1)) ? '0 : winner + IdxWidth'(1);

  always_comb begin
    init_gnt_o         = '0;
    init_gnt_o[winner] = hs;
  end

  // Read data and id come straight from the bank; only the target strobe is tracked.
  always_comb begin
    init_r_valid_o             = '0;
    init_r_valid_o[resp_idx_q] = resp_valid_q;
  end

  assign init_r_data_o = bank_r_data_i;
  assign init_r_id_o   = bank_r_id_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
    end else begin
      resp_valid_q <= hs;
      if (hs) begin
        rr_ptr_q   <= ptr_next;
        resp_idx_q <= winner;
      end
    end
  end

endmodule

// File: tb/tb_tcdm_bank_rr_arbiter.sv
// tb/tb_tcdm_bank_rr_arbiter.sv - self-checking bench for tcdm_bank_rr_arbiter
module tb_tcdm_bank_rr_arbiter;

  localparam int N = 4;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req;
  logic [N-1:0][31:0]   add;
  logic [N-1:0]         wen;
  logic [N-1:0][31:0]   data;
  logic [N-1:0][3:0]    be;
  logic [N-1:0][0:0]    id;
  logic [N-1:0]         gnt_o;
  logic [N-1:0]         r_valid_o;
  logic [31:0]          r_data_o;
  logic [0:0]           r_id_o;
  logic                 bank_req;
  logic [31:0]          bank_add;
  logic                 bank_wen;
  logic [31:0]          bank_data;
  logic [3:0]           bank_be;
  logic [0:0]           bank_id;
  logic                 bank_gnt;
  logic [31:0]          bank_r_data;
  logic [0:0]           bank_r_id;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;
  int resp_m = -1;

  tcdm_bank_rr_arbiter #(
    .NbInit(N), .AddrWidth(32), .DataWidth(32), .BeWidth(4), .IdWidth(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .init_req_i(req), .init_add_i(add), .init_wen_i(wen), .init_data_i(data),
    .init_be_i(be), .init_id_i(id),
    .init_gnt_o(gnt_o), .init_r_valid_o(r_valid_o), .init_r_data_o(r_data_o),
    .init_r_id_o(r_id_o),
    .bank_req_o(bank_req), .bank_add_o(bank_add), .bank_wen_o(bank_wen),
    .bank_data_o(bank_data), .bank_be_o(bank_be), .bank_id_o(bank_id),
    .bank_gnt_i(bank_gnt), .bank_r_data_i(bank_r_data), .bank_r_id_i(bank_r_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Compare every output against the reference model for the current inputs.
  task automatic drive_check();
    int w;
    logic [N-1:0] eg;
    logic [N-1:0] ev;
    #1;
    w  = model_pick(req, ptr_m);
    eg = '0;
    if (w >= 0 && bank_gnt) eg[w] = 1'b1;
    ev = '0;
    if (resp_m >= 0) ev[resp_m] = 1'b1;
    chk("gnt", gnt_o, eg);
    chk("r_valid", r_valid_o, ev);
    chk("bank_req", bank_req, (w >= 0));
    chk("r_data", r_data_o, bank_r_data);
    chk("r_id", r_id_o, bank_r_id);
    if (w >= 0) begin
      chk("bank_add", bank_add, add[w]);
      chk("bank_wen", bank_wen, wen[w]);
      chk("bank_data", bank_data, data[w]);
      chk("bank_be", bank_be, be[w]);
      chk("bank_id", bank_id, id[w]);
    end
  endtask

  task automatic tick();
    int w;
    @(posedge clk);
    w = model_pick(req, ptr_m);
    if (w >= 0 && bank_gnt) begin
      resp_m = w;
      ptr_m  = (w + 1) % N;
    end else begin
      resp_m = -1;
    end
    #1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      add[i]  = $urandom;
      wen[i]  = 1'($urandom_range(0, 1));
      data[i] = $urandom;
      be[i]   = 4'($urandom_range(0, 15));
      id[i]   = 1'($urandom_range(0, 1));
    end
    bank_r_data = $urandom;
    bank_r_id   = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = 4'b0101;
    bank_gnt = 1'b0;
    #1;
    chk("rst_r_valid", r_valid_o, 4'b0000);
    chk("rst_bank_req", bank_req, 1'b1);
    chk("rst_gnt_off", gnt_o, 4'b0000);
    bank_gnt = 1'b1;
    #1;
    chk("rst_gnt_comb", gnt_o, 4'b0001);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ptr", dut.rr_ptr_q, 2'd0);
    req   = '0;
    rst_n = 1'b1;
    ptr_m  = 0;
    resp_m = -1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         gnt;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0000};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 4'b0010};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 4'b0100};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b1000};
    vecs[5]  = '{4'b1010, 1'b0, 4'b0000, 4'b0001};
    vecs[6]  = '{4'b1010, 1'b0, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b1010, 1'b1, 4'b0010, 4'b0000};
    vecs[8]  = '{4'b1001, 1'b1, 4'b1000, 4'b0010};
    vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 4'b1000};
    vecs[10] = '{4'b0110, 1'b1, 4'b0010, 4'b0000};
    vecs[11] = '{4'b0011, 1'b1, 4'b0001, 4'b0010};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0001};

    rand_fields();
    do_reset();

    // Single read from initiator 2
    add[2] = 32'h100; wen[2] = 1'b1; id[2] = 1'b1;
    req = 4'b0100; bank_gnt = 1'b1;
    drive_check();
    chk("rd_gnt", gnt_o, 4'b0100);
    chk("rd_add", bank_add, 32'h100);
    tick();
    req = '0; bank_r_data = 32'hCAFE_0123; bank_r_id = 1'b1;
    drive_check();
    chk("rd_rvalid", r_valid_o, 4'b0100);
    chk("rd_rdata", r_data_o, 32'hCAFE_0123);
    chk("rd_rid", r_id_o, 1'b1);
    chk("rd_ptr", dut.rr_ptr_q, 2'd3);

    // Wrap from pointer 3 with sparse requests
    req = 4'b0011;
    drive_check();
    chk("wrap_gnt0", gnt_o, 4'b0001);
    tick();
    drive_check();
    chk("wrap_gnt1", gnt_o, 4'b0010);
    tick();
    req = '0;
    drive_check();
    chk("wrap_ptr", dut.rr_ptr_q, 2'd2);

    rand_fields();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req = vecs[i].req; bank_gnt = vecs[i].gnt;
      drive_check();
      chk($sformatf("vec%0d_gnt", i), gnt_o, vecs[i].exp_gnt);
      chk($sformatf("vec%0d_rv", i), r_valid_o, vecs[i].exp_rv);
      tick();
    end

    // Write from initiator 3
    req = 4'b1000; bank_gnt = 1'b1;
    wen[3] = 1'b0; data[3] = 32'hDEAD_BEEF; be[3] = 4'b0011;
    drive_check();
    chk("wr_wen", bank_wen, 1'b0);
    chk("wr_be", bank_be, 4'b0011);
    chk("wr_data", bank_data, 32'hDEAD_BEEF);
    tick();
    req = '0;
    drive_check();
    chk("wr_rvalid", r_valid_o, 4'b1000);
    tick();
    drive_check();
    chk("wr_rvalid_off", r_valid_o, 4'b0000);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      req = 4'($urandom_range(0, 15));
      bank_gnt = ($urandom_range(0, 3) != 0);
      drive_check();
      tick();
    end

    // Reset in the cycle after a handshake
    req = 4'b0010; bank_gnt = 1'b1;
    drive_check();
    tick();
    req = '0;
    drive_check();
    chk("mid_rv_before", r_valid_o, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("mid_rv_reset", r_valid_o, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr_m = 0; resp_m = -1;
    chk("mid_ptr", dut.rr_ptr_q, 2'd0);
    req = 4'b1111;
    drive_check();
    chk("mid_gnt", gnt_o, 4'b0001);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
